// File: rtl/seg7_pkg.sv
// seg7_pkg: shared widths, snapshot payload and hex-to-segment table for the
// 8-digit multiplexed seven-segment display driver.
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned VAL_W      = NUM_DIGITS * NIB_W;
  localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);

  // Active-high segment patterns, bit0 = a ... bit6 = g.
  localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  // Frame snapshot: what the display shows for a whole frame.
  typedef struct packed {
    logic [VAL_W-1:0]      value;
    logic [NUM_DIGITS-1:0] dp;
    logic                  blank;
  } snap_t;

  function automatic logic [SEG_W-1:0] hex2seg(input logic [NIB_W-1:0] nibble);
    return SEG_TABLE[nibble];
  endfunction

endpackage

// File: rtl/seg7_scan_if.sv
// seg7_scan_if: display word/controls from the CPU side and the board-facing
// scan outputs.
//   value_in/dp_in/blank_lz/freeze : producer -> scanner
//   anode_out/seg_out/dp_out/frame_done : scanner -> board / observer
interface seg7_scan_if;
  import seg7_pkg::*;

  logic [VAL_W-1:0]      value_in;
  logic [NUM_DIGITS-1:0] dp_in;
  logic                  blank_lz;
  logic                  freeze;
  logic [NUM_DIGITS-1:0] anode_out;
  logic [SEG_W-1:0]      seg_out;
  logic                  dp_out;
  logic                  frame_done;

  modport master (
    output value_in, dp_in, blank_lz, freeze,
    input  anode_out, seg_out, dp_out, frame_done
  );

  modport slave (
    input  value_in, dp_in, blank_lz, freeze,
    output anode_out, seg_out, dp_out, frame_done
  );

endinterface

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: combinational nibble -> active-high segments (gfedcba).
//   nibble : 4-bit hex digit
//   seg_c  : active-high segment pattern
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [NIB_W-1:0] nibble,
  output logic [SEG_W-1:0] seg_c
);

  assign seg_c = hex2seg(nibble);

endmodule

// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed 8-digit hex display driver. Snapshots the
// display word once per frame, scans one digit per refresh slot and drives
// anodes, segments and decimal point with optional leading-zero blanking.
//   clk, rst : clock and synchronous active-high reset
//   bus      : seg7_scan_if.slave (value_in, dp_in, blank_lz, freeze in;
//              anode_out, seg_out, dp_out, frame_done out)
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_DIV    = 100000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  seg7_scan_if.slave   bus
);

  localparam int unsigned PRE_W = $clog2(REFRESH_DIV);
  localparam logic [PRE_W-1:0]      PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [SEG_W-1:0]      SEG_XOR  = SEG_ACTIVE_LOW ? '1 : '0;
  localparam logic [NUM_DIGITS-1:0] AN_XOR   = AN_ACTIVE_LOW ? '1 : '0;
  localparam logic                  DP_XOR   = SEG_ACTIVE_LOW;

  logic [PRE_W-1:0] presc;
  logic [IDX_W-1:0] idx;
  snap_t            snap;
  logic             load_pending;

  logic                  tick_c;
  logic                  wrap_c;
  logic                  load_c;
  logic [4:0]            shamt_c;
  logic [NIB_W-1:0]      nibble_c;
  logic [SEG_W-1:0]      dec_seg_c;
  logic                  hide_c;
  logic [NUM_DIGITS-1:0] anode_raw_c;
  logic [SEG_W-1:0]      seg_raw_c;
  logic                  dp_raw_c;

  // Slot/frame timing and snapshot load decision.
  assign tick_c = (presc == PRE_LAST);
  assign wrap_c = tick_c && (idx == IDX_LAST);
  assign load_c = load_pending || (wrap_c && !bus.freeze);

  // Current digit nibble and its decoded pattern.
  assign shamt_c  = {idx, 2'b00};
  assign nibble_c = snap.value[shamt_c +: NIB_W];

  seg7_hex_decode u_dec (
    .nibble (nibble_c),
    .seg_c  (dec_seg_c)
  );

  // A digit is hidden when it and every digit to its left are zero; digit 0
  // always shows so a zero word still reads "0".
  always_comb begin
    hide_c      = 1'b0;
    anode_raw_c = '0;
    seg_raw_c   = '0;
    dp_raw_c    = 1'b0;
    if (snap.blank && (idx != '0) && ((snap.value >> shamt_c) == '0)) begin
      hide_c = 1'b1;
    end
    if (!hide_c) begin
      anode_raw_c = NUM_DIGITS'(1) << idx;
      seg_raw_c   = dec_seg_c;
      dp_raw_c    = snap.dp[idx];
    end
  end

  // Prescaler, digit index, snapshot and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc          <= '0;
      idx            <= '0;
      snap           <= '0;
      load_pending   <= 1'b1;
      bus.anode_out  <= AN_XOR;
      bus.seg_out    <= SEG_XOR;
      bus.dp_out     <= DP_XOR;
      bus.frame_done <= 1'b0;
    end else begin
      presc <= tick_c ? '0 : presc + PRE_W'(1);
      if (tick_c) begin
        idx <= idx + IDX_W'(1);
      end
      if (load_c) begin
        snap.value <= bus.value_in;
        snap.dp    <= bus.dp_in;
        snap.blank <= bus.blank_lz;
      end
      load_pending   <= 1'b0;
      bus.anode_out  <= anode_raw_c ^ AN_XOR;
      bus.seg_out    <= seg_raw_c ^ SEG_XOR;
      bus.dp_out     <= dp_raw_c ^ DP_XOR;
      bus.frame_done <= wrap_c;
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: scoreboard bench for seg7_scan with REFRESH_DIV=4 and
// active-low anodes/segments. A reference model derives the expected display
// from the number of clocks since reset; a monitor compares every cycle.
module tb_seg7_scan;

  localparam int unsigned DIV    = 4;
  localparam int unsigned FRAME  = 8 * DIV;
  localparam bit          SEG_LO = 1'b1;
  localparam bit          AN_LO  = 1'b1;

  localparam logic [6:0] HEX_REF [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } out_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  seg7_scan_if bus ();

  seg7_scan #(
    .REFRESH_DIV    (DIV),
    .SEG_ACTIVE_LOW (SEG_LO),
    .AN_ACTIVE_LOW  (AN_LO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [3:0] dec_nib = 4'd0;
  logic [6:0] dec_seg;

  seg7_hex_decode u_dec_tb (
    .nibble (dec_nib),
    .seg_c  (dec_seg)
  );

  always #5 clk = ~clk;

  // Board-level view of one digit slot, polarity applied.
  function automatic out_t display(input int d, input logic [31:0] v,
                                   input logic [7:0] dpv, input logic bl,
                                   input logic fd);
    out_t o;
    logic [31:0] upper;
    logic [3:0]  nib;
    bit          hide;
    upper = v >> (4 * d);
    nib   = upper[3:0];
    hide  = bl && (d != 0) && (upper == 32'd0);
    o.an  = hide ? 8'h00 : (8'h01 << d);
    o.seg = hide ? 7'h00 : HEX_REF[nib];
    o.dp  = hide ? 1'b0 : dpv[d];
    if (AN_LO)  o.an  = ~o.an;
    if (SEG_LO) begin
      o.seg = ~o.seg;
      o.dp  = ~o.dp;
    end
    o.fd = fd;
    return o;
  endfunction

  // Reference model: time since reset decides digit and frame boundaries.
  out_t        exp_q[$];
  bit          m_started = 1'b0;
  int          m_cnt = 0;
  logic [31:0] m_val = '0;
  logic [7:0]  m_dp = '0;
  logic        m_blank = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      out_t r;
      r.an  = AN_LO ? 8'hFF : 8'h00;
      r.seg = SEG_LO ? 7'h7F : 7'h00;
      r.dp  = SEG_LO;
      r.fd  = 1'b0;
      exp_q.push_back(r);
      m_started = 1'b1;
      m_cnt     = 0;
      m_val     = '0;
      m_dp      = '0;
      m_blank   = 1'b0;
    end else if (m_started) begin
      int digit;
      bit boundary;
      digit    = (m_cnt / DIV) % 8;
      boundary = (m_cnt % FRAME) == (FRAME - 1);
      exp_q.push_back(display(digit, m_val, m_dp, m_blank, boundary));
      if (m_cnt == 0 || (boundary && !bus.freeze)) begin
        m_val   = bus.value_in;
        m_dp    = bus.dp_in;
        m_blank = bus.blank_lz;
      end
      m_cnt++;
    end
  end

  // Monitor: one comparison per cycle, sampled away from the active edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      out_t e, g;
      e = exp_q.pop_front();
      g.an  = bus.anode_out;
      g.seg = bus.seg_out;
      g.dp  = bus.dp_out;
      g.fd  = bus.frame_done;
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL scan t=%0t got an=%h seg=%h dp=%b fd=%b want an=%h seg=%h dp=%b fd=%b",
                 $time, g.an, g.seg, g.dp, g.fd, e.an, e.seg, e.dp, e.fd);
      end
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_in(input logic [31:0] v, input logic [7:0] d,
                        input logic bl, input logic fz);
    bus.value_in = v;
    bus.dp_in    = d;
    bus.blank_lz = bl;
    bus.freeze   = fz;
  endtask

  initial begin
    set_in(32'h1234_ABCD, 8'h00, 1'b0, 1'b0);
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    run(2 * FRAME + 3);

    // Leading-zero blanking, then an all-zero word.
    set_in(32'h0000_00F0, 8'h00, 1'b1, 1'b0);
    run(2 * FRAME);
    set_in(32'h0000_0000, 8'h01, 1'b1, 1'b0);
    run(2 * FRAME);

    // Freeze holds the 1s while the input moves on.
    set_in(32'h1111_1111, 8'h00, 1'b0, 1'b0);
    run(2 * FRAME);
    set_in(32'h1111_1111, 8'h00, 1'b0, 1'b1);
    run(7);
    set_in(32'h2222_2222, 8'hA5, 1'b0, 1'b1);
    run(2 * FRAME + 5);
    bus.freeze = 1'b0;
    run(2 * FRAME);

    // Reset while digit 5 is lit; value_in is captured straight away.
    set_in(32'h1234_ABCD, 8'h00, 1'b0, 1'b0);
    run(FRAME + 1);
    begin
      int n;
      n = 0;
      while (bus.anode_out !== 8'hDF && n < 2 * FRAME) begin
        run(1);
        n++;
      end
      checks++;
      if (bus.anode_out !== 8'hDF) begin
        errors++;
        $display("FAIL digit5_wait got an=%h want an=df within %0d cycles",
                 bus.anode_out, 2 * FRAME);
      end
    end
    set_in(32'hCAFE_0042, 8'h3C, 1'b1, 1'b1);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    run(FRAME + 4);

    // Randomized words, leading zeros, dp, freeze, mid-frame changes, resets.
    for (int it = 0; it < 40; it++) begin
      logic [31:0] v;
      int          nz;
      v  = $urandom();
      nz = $urandom_range(0, 8);
      v  = (nz == 8) ? 32'd0 : (v >> (4 * nz));
      set_in(v, 8'($urandom()), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 15) == 0) begin
        rst = 1'b1;
        run(1);
        rst = 1'b0;
      end
      run($urandom_range(1, 2 * FRAME));
    end

    // Drain: the last pushed expectation is popped at this negedge.
    run(1);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end

    // Exhaustive decoder check in isolation.
    for (int n = 0; n < 16; n++) begin
      dec_nib = 4'(n);
      #1;
      checks++;
      if (dec_seg !== HEX_REF[n]) begin
        errors++;
        $display("FAIL hex_decode nib=%h got %b want %b", n, dec_seg, HEX_REF[n]);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
